err_delay_tuner: RTL and testbench

//  Closed-loop configurator for the token pipeline stage's tunable sampling delay.

---
 rtl/err_delay_tuner.sv | 203 ++++++++++++++++++++
 tb/tb_err_delay_tuner.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/err_delay_tuner.sv
// ---------------------------------------------------------------------------
// err_delay_tuner
// Closed-loop tuner for the token pipeline stage's sampling delay line.
// Dual-rail timing-error results are counted over a window of tokens. At the
// end of each window the delay-line select is stepped up when there were
// many errors (more margin) or down when there were few (more speed). After
// any change of the select, a number of tokens is ignored so the stage can
// settle before measuring again.
//
// Ports
//   i_clk        clock, all state on rising edge
//   i_rst_n      asynchronous reset, active low
//   i_en         tuning enable; low -> idle, counters cleared, select kept
//   i_err1       error rail: 1 = timing error on this token
//   i_err0       clean rail: 1 = token sampled without error
//   i_force_load single-cycle pulse: load i_force_sel (clamped)
//   i_force_sel  select value to load on i_force_load
//   o_delay_sel  delay-line select to the pipeline stage
//   o_sel_upd    one-cycle pulse, coincident with a changed o_delay_sel
//   o_err_cnt    errors counted in the current window (debug)
//   o_proto_err  sticky flag: both rails seen high together
// ---------------------------------------------------------------------------
module err_delay_tuner #(
    parameter int SEL_W    = 3,
    parameter int SEL_MIN  = 0,
    parameter int SEL_MAX  = 7,
    parameter int SEL_INIT = 3,
    parameter int WINDOW   = 32,
    parameter int CNT_W    = 6,
    parameter int HI_THR   = 4,
    parameter int LO_THR   = 0,
    parameter int HOLD_EV  = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_err1,
    input  logic             i_err0,
    input  logic             i_force_load,
    input  logic [SEL_W-1:0] i_force_sel,
    output logic [SEL_W-1:0] o_delay_sel,
    output logic             o_sel_upd,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic             o_proto_err
);

    localparam int HOLD_W = $clog2(HOLD_EV + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_ADJUST,
        ST_HOLD
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [1:0]         r_prev_rails;
    logic [CNT_W-1:0]   r_tok_cnt;
    logic [CNT_W-1:0]   w_tok_cnt_next;
    logic [CNT_W-1:0]   r_err_cnt;
    logic [CNT_W-1:0]   w_err_cnt_next;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [HOLD_W-1:0]  w_hold_cnt_next;
    logic [SEL_W-1:0]   r_delay_sel;
    logic [SEL_W-1:0]   w_delay_sel_next;
    logic               r_sel_upd;
    logic               w_sel_upd_next;
    logic               r_proto_err;
    logic               w_proto_err_next;

    logic [1:0]         w_rails;
    logic               w_event;
    logic               w_err_event;
    logic               w_step_up;
    logic               w_step_dn;
    logic [SEL_W-1:0]   w_force_clamp;

    assign w_rails = {i_err1, i_err0};

    // 4-phase handshake: a token is the first non-spacer code after a spacer,
    // so rails held high for many cycles still produce a single event.
    assign w_event     = (r_prev_rails == 2'b00) && (w_rails != 2'b00);
    assign w_err_event = w_event && i_err1;

    // Comparisons are done in int so that limits of 0 compare cleanly.
    assign w_step_up = (int'(r_err_cnt) >= HI_THR) && (int'(r_delay_sel) < SEL_MAX);
    assign w_step_dn = (int'(r_err_cnt) <= LO_THR) && (int'(r_delay_sel) > SEL_MIN);

    always_comb begin
        if (int'(i_force_sel) < SEL_MIN) begin
            w_force_clamp = SEL_W'(SEL_MIN);
        end else if (int'(i_force_sel) > SEL_MAX) begin
            w_force_clamp = SEL_W'(SEL_MAX);
        end else begin
            w_force_clamp = i_force_sel;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_tok_cnt_next   = r_tok_cnt;
        w_err_cnt_next   = r_err_cnt;
        w_hold_cnt_next  = r_hold_cnt;
        w_delay_sel_next = r_delay_sel;
        w_sel_upd_next   = 1'b0;
        // The illegal 11 code is flagged whenever it appears, in any state.
        w_proto_err_next = r_proto_err | (w_rails == 2'b11);

        if (i_force_load) begin
            w_delay_sel_next = w_force_clamp;
            w_sel_upd_next   = (w_force_clamp != r_delay_sel);
            w_tok_cnt_next   = '0;
            w_err_cnt_next   = '0;
            w_hold_cnt_next  = '0;
            w_state_next     = i_en ? ST_HOLD : ST_IDLE;
        end else if (!i_en) begin
            w_tok_cnt_next   = '0;
            w_err_cnt_next   = '0;
            w_hold_cnt_next  = '0;
            w_state_next     = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_tok_cnt_next  = '0;
                    w_err_cnt_next  = '0;
                    w_hold_cnt_next = '0;
                    w_state_next    = ST_COUNT;
                end
                ST_COUNT: begin
                    if (w_event) begin
                        w_tok_cnt_next = r_tok_cnt + 1'b1;
                        if (w_err_event && (r_err_cnt != '1)) begin
                            w_err_cnt_next = r_err_cnt + 1'b1;
                        end
                        if (r_tok_cnt == CNT_W'(WINDOW - 1)) begin
                            w_state_next = ST_ADJUST;
                        end
                    end
                end
                ST_ADJUST: begin
                    // Events arriving in this cycle are deliberately dropped.
                    w_tok_cnt_next  = '0;
                    w_err_cnt_next  = '0;
                    w_hold_cnt_next = '0;
                    if (w_step_up) begin
                        w_delay_sel_next = r_delay_sel + 1'b1;
                        w_sel_upd_next   = 1'b1;
                        w_state_next     = ST_HOLD;
                    end else if (w_step_dn) begin
                        w_delay_sel_next = r_delay_sel - 1'b1;
                        w_sel_upd_next   = 1'b1;
                        w_state_next     = ST_HOLD;
                    end else begin
                        w_state_next     = ST_COUNT;
                    end
                end
                ST_HOLD: begin
                    // Settling period: tokens only advance hold_cnt.
                    if (w_event) begin
                        if (r_hold_cnt == HOLD_W'(HOLD_EV - 1)) begin
                            w_hold_cnt_next = '0;
                            w_state_next    = ST_COUNT;
                        end else begin
                            w_hold_cnt_next = r_hold_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_prev_rails <= 2'b00;
            r_tok_cnt    <= '0;
            r_err_cnt    <= '0;
            r_hold_cnt   <= '0;
            r_delay_sel  <= SEL_W'(SEL_INIT);
            r_sel_upd    <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_prev_rails <= w_rails;
            r_tok_cnt    <= w_tok_cnt_next;
            r_err_cnt    <= w_err_cnt_next;
            r_hold_cnt   <= w_hold_cnt_next;
            r_delay_sel  <= w_delay_sel_next;
            r_sel_upd    <= w_sel_upd_next;
            r_proto_err  <= w_proto_err_next;
        end
    end

    assign o_delay_sel = r_delay_sel;
    assign o_sel_upd   = r_sel_upd;
    assign o_err_cnt   = r_err_cnt;
    assign o_proto_err = r_proto_err;

endmodule

// File: tb/tb_err_delay_tuner.sv
module tb_err_delay_tuner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       err1;
    logic       err0;
    logic       force_load;
    logic [2:0] force_sel;
    logic       force_load4;
    logic [3:0] force_sel4;

    logic [2:0] delay_sel;
    logic       sel_upd;
    logic [5:0] err_cnt;
    logic       proto_err;
    logic [3:0] delay_sel4;
    logic       sel_upd4;
    logic [5:0] err_cnt4;
    logic       proto_err4;

    int n_vec = 0;
    int n_mis = 0;
    int cur_sel;

    always #5 clk = ~clk;

    err_delay_tuner dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_err1       (err1),
        .i_err0       (err0),
        .i_force_load (force_load),
        .i_force_sel  (force_sel),
        .o_delay_sel  (delay_sel),
        .o_sel_upd    (sel_upd),
        .o_err_cnt    (err_cnt),
        .o_proto_err  (proto_err)
    );

    // Wider select variant used to exercise clamping above SEL_MAX.
    err_delay_tuner #(.SEL_W(4), .SEL_MAX(7)) dut4 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_err1       (err1),
        .i_err0       (err0),
        .i_force_load (force_load4),
        .i_force_sel  (force_sel4),
        .o_delay_sel  (delay_sel4),
        .o_sel_upd    (sel_upd4),
        .o_err_cnt    (err_cnt4),
        .o_proto_err  (proto_err4)
    );

    typedef struct {
        int n_err;
        int exp_sel;
        int exp_upd;
    } win_vec_t;

    win_vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_rails(input logic [1:0] r);
        {err1, err0} = r;
        tick();
        {err1, err0} = 2'b00;
        tick();
    endtask

    task automatic send_tok(input bit e);
        send_rails(e ? 2'b10 : 2'b01);
    endtask

    task automatic hold_tokens();
        for (int i = 0; i < 8; i++) send_tok(1'b1);
        chk("hold err_cnt", int'(err_cnt), 0);
    endtask

    task automatic do_force(input int v, input int exp_sel, input int exp_upd);
        force_sel  = 3'(v);
        force_load = 1'b1;
        tick();
        force_load = 1'b0;
        chk("force delay_sel", int'(delay_sel), exp_sel);
        chk("force sel_upd", int'(sel_upd), exp_upd);
        tick();
        chk("force sel_upd end", int'(sel_upd), 0);
        cur_sel = exp_sel;
    endtask

    // One 32-token window, errors on the first n_err tokens.
    task automatic run_window(input int idx, input int n_err, input int exp_sel, input int exp_upd);
        for (int t = 0; t < 31; t++) send_tok(t < n_err);
        chk($sformatf("win%0d err_cnt@31", idx), int'(err_cnt), n_err);
        chk($sformatf("win%0d sel@31", idx), int'(delay_sel), cur_sel);
        send_tok(1'b0);
        chk($sformatf("win%0d delay_sel", idx), int'(delay_sel), exp_sel);
        chk($sformatf("win%0d sel_upd", idx), int'(sel_upd), exp_upd);
        chk($sformatf("win%0d err_cnt clr", idx), int'(err_cnt), 0);
        tick();
        chk($sformatf("win%0d sel_upd end", idx), int'(sel_upd), 0);
        cur_sel = exp_sel;
        if (exp_upd != 0) hold_tokens();
    endtask

    initial begin
        vecs[0] = '{0, 2, 1};
        vecs[1] = '{5, 3, 1};
        vecs[2] = '{5, 4, 1};
        vecs[3] = '{2, 4, 0};
        vecs[4] = '{0, 3, 1};
        vecs[5] = '{4, 4, 1};
        vecs[6] = '{3, 4, 0};
        vecs[7] = '{1, 4, 0};

        rst_n = 1'b0; en = 1'b0; err1 = 1'b0; err0 = 1'b0;
        force_load = 1'b0; force_sel = '0; force_load4 = 1'b0; force_sel4 = '0;
        #12;
        chk("rst delay_sel", int'(delay_sel), 3);
        chk("rst sel_upd", int'(sel_upd), 0);
        chk("rst err_cnt", int'(err_cnt), 0);
        chk("rst proto_err", int'(proto_err), 0);
        chk("rst delay_sel4", int'(delay_sel4), 3);
        tick();
        rst_n = 1'b1;
        en    = 1'b1;
        tick();                               // IDLE -> COUNT
        cur_sel = 3;

        // Table-driven windows
        for (int i = 0; i < 8; i++) run_window(i, vecs[i].n_err, vecs[i].exp_sel, vecs[i].exp_upd);

        // Rails held non-spacer: a single (error) event
        chk("pre proto_err", int'(proto_err), 0);
        {err1, err0} = 2'b10;
        repeat (20) tick();
        {err1, err0} = 2'b00;
        tick();
        chk("held err_cnt", int'(err_cnt), 1);
        for (int t = 0; t < 30; t++) send_tok(1'b0);
        chk("held err_cnt@31", int'(err_cnt), 1);
        send_tok(1'b0);
        chk("held win delay_sel", int'(delay_sel), 4);
        chk("held win sel_upd", int'(sel_upd), 0);
        tick();
        // Illegal 11 after spacer
        send_rails(2'b11);
        chk("11 proto_err", int'(proto_err), 1);
        chk("11 err_cnt", int'(err_cnt), 1);
        for (int t = 0; t < 3; t++) send_tok(1'b0);
        chk("proto_err sticky", int'(proto_err), 1);

        // Forced limits
        do_force(7, 7, 1);
        hold_tokens();
        run_window(10, 5, 7, 0);
        do_force(0, 0, 1);
        hold_tokens();
        run_window(11, 0, 0, 0);
        do_force(0, 0, 0);
        hold_tokens();
        force_sel4 = 4'd9; force_load4 = 1'b1;
        tick();
        force_load4 = 1'b0;
        chk("clamp9 delay_sel4", int'(delay_sel4), 7);
        chk("clamp9 sel_upd4", int'(sel_upd4), 1);
        force_sel4 = 4'd2; force_load4 = 1'b1;
        tick();
        force_load4 = 1'b0;
        chk("force2 delay_sel4", int'(delay_sel4), 2);

        // Asynchronous reset mid-window
        do_force(5, 5, 1);
        hold_tokens();
        for (int t = 0; t < 20; t++) send_tok(t < 3);
        chk("mid err_cnt", int'(err_cnt), 3);
        #1 rst_n = 1'b0;
        #1;
        chk("async delay_sel", int'(delay_sel), 3);
        chk("async sel_upd", int'(sel_upd), 0);
        chk("async err_cnt", int'(err_cnt), 0);
        chk("async proto_err", int'(proto_err), 0);
        tick();
        chk("rst held sel_upd", int'(sel_upd), 0);
        rst_n = 1'b1;
        tick();                               // IDLE -> COUNT
        cur_sel = 3;

        // en low mid-window
        do_force(6, 6, 1);
        hold_tokens();
        for (int t = 0; t < 10; t++) send_tok(t < 2);
        chk("en mid err_cnt", int'(err_cnt), 2);
        en = 1'b0;
        tick();
        chk("en low err_cnt", int'(err_cnt), 0);
        chk("en low delay_sel", int'(delay_sel), 6);
        do_force(2, 2, 1);                    // force while idle
        en = 1'b1;
        tick();                               // IDLE -> COUNT
        run_window(20, 0, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
